// File: rtl/fetch_line_sequencer.sv
// fetch_line_sequencer
// Fetches one I-cache line at a time, buffers it, and issues the buffered
// instructions to decode one per cycle in program order. Handles redirects,
// drops stale responses and converts faults / misaligned PCs into a single
// exception-tagged NOP, after which it halts until the next redirect.
//
// Optional build macro: LEN5_FETCH_BYPASS_EN
//   When defined, the instruction at the current offset is issued directly
//   from the cache response in the cycle it arrives (0-cycle latency).
//   When undefined, issue starts the cycle after the line is captured.
module fetch_line_sequencer #(
    parameter int unsigned       XLEN       = 64,
    parameter int unsigned       ILEN       = 32,
    parameter int unsigned       LINE_INSTR = 16,
    parameter logic [XLEN-1:0]   BOOT_PC    = '0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic [XLEN-1:0]            redirect_pc_i,
    output logic                       cache_req_valid_o,
    input  logic                       cache_req_ready_i,
    output logic [XLEN-1:0]            cache_req_addr_o,
    input  logic                       cache_resp_valid_i,
    output logic                       cache_resp_ready_o,
    input  logic [LINE_INSTR*ILEN-1:0] cache_resp_line_i,
    input  logic                       cache_resp_except_i,
    input  logic [4:0]                 cache_resp_except_code_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [XLEN-1:0]            instr_pc_o,
    output logic [ILEN-1:0]            instr_o,
    output logic                       instr_except_o,
    output logic [4:0]                 instr_except_code_o
);

    localparam int unsigned    OW  = $clog2(LINE_INSTR);   // offset width
    localparam int unsigned    LBW = OW + 2;               // log2(line bytes)
    localparam logic [ILEN-1:0] NOP = ILEN'(32'h13);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t                     state_q;
    logic [XLEN-1:0]            pc_q;
    logic [LINE_INSTR*ILEN-1:0] line_q;
    logic                       exc_q;
    logic [4:0]                 exc_code_q;

    logic [OW-1:0]   offset;
    logic            last_in_line;
    logic [XLEN-1:0] line_addr;
    logic            pc_aligned;

    assign offset       = pc_q[LBW-1:2];
    assign last_in_line = &offset;
    assign line_addr    = {pc_q[XLEN-1:LBW], {LBW{1'b0}}};
    assign pc_aligned   = (pc_q[1:0] == 2'b00);

    logic            issue_valid;
    logic [ILEN-1:0] issue_word;
    logic            issue_exc;
    logic [4:0]      issue_code;

    // Select the instruction presented to decode this cycle (buffer or bypass).
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        issue_valid = 1'b0;
        issue_word  = '0;
        issue_exc   = 1'b0;
        issue_code  = '0;
        if (state_q == S_ISSUE && !flush_i) begin
            issue_valid = 1'b1;
            issue_word  = line_q[offset*ILEN +: ILEN];
            issue_exc   = exc_q;
            issue_code  = exc_code_q;
        end
`ifdef LEN5_FETCH_BYPASS_EN
        else if (state_q == S_WAIT && cache_resp_valid_i && !flush_i) begin
            issue_valid = 1'b1;
            issue_word  = cache_resp_line_i[offset*ILEN +: ILEN];
            issue_exc   = cache_resp_except_i;
            issue_code  = cache_resp_except_code_i;
        end
`endif
    end

    // Outputs decode registered state; everything is held at 0 while in reset.
    assign cache_req_valid_o   = rst_ni && (state_q == S_REQ) && pc_aligned;
    assign cache_req_addr_o    = rst_ni ? line_addr : '0;
    assign cache_resp_ready_o  = rst_ni && (state_q == S_WAIT || state_q == S_DRAIN);
    assign instr_valid_o       = rst_ni && issue_valid;
    assign instr_pc_o          = rst_ni ? pc_q : '0;
    assign instr_o             = instr_valid_o ? (issue_exc ? NOP : issue_word) : '0;
    assign instr_except_o      = instr_valid_o && issue_exc;
    assign instr_except_code_o = instr_except_o ? issue_code : '0;

    // Sequencer FSM: PC, line buffer, exception tag and state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_REQ;
            pc_q       <= BOOT_PC;
            // NOTE: the line buffer is reset so its contents are never X;
            // it is a flat register, not a RAM, so this costs only reset fan-out.
            line_q     <= '0;
            exc_q      <= 1'b0;
            exc_code_q <= '0;
        end else if (flush_i) begin
            // NOTE: non-blocking assignments throughout so every register sees
            // the pre-edge values, independent of statement order.
            pc_q       <= redirect_pc_i;
            exc_q      <= 1'b0;
            exc_code_q <= '0;
            // Keep at most one request outstanding: if one is in flight, drain it.
            unique case (state_q)
                S_REQ:   state_q <= (pc_aligned && cache_req_ready_i) ? S_DRAIN : S_REQ;
                S_WAIT:  state_q <= cache_resp_valid_i ? S_REQ : S_DRAIN;
                S_DRAIN: state_q <= cache_resp_valid_i ? S_REQ : S_DRAIN;
                default: state_q <= S_REQ;
            endcase
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (!pc_aligned) begin
                        exc_q      <= 1'b1;
                        exc_code_q <= 5'h00;
                        state_q    <= S_ISSUE;
                    end else if (cache_req_ready_i) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cache_resp_valid_i) begin
                        line_q     <= cache_resp_line_i;
                        exc_q      <= cache_resp_except_i;
                        exc_code_q <= cache_resp_except_code_i;
                        state_q    <= S_ISSUE;
`ifdef LEN5_FETCH_BYPASS_EN
                        if (instr_ready_i) begin
                            if (cache_resp_except_i) begin
                                state_q <= S_HALT;
                            end else begin
                                pc_q <= pc_q + XLEN'(4);
                                if (last_in_line) state_q <= S_REQ;
                            end
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    if (instr_ready_i) begin
                        if (exc_q) begin
                            state_q <= S_HALT;
                        end else begin
                            pc_q <= pc_q + XLEN'(4);
                            if (last_in_line) state_q <= S_REQ;
                        end
                    end
                end
                S_DRAIN: begin
                    if (cache_resp_valid_i) state_q <= S_REQ;
                end
                default: ;  // S_HALT waits for a flush
            endcase
        end
    end

endmodule

// File: doc/fetch_line_sequencer.md
Name: fetch_line_sequencer

Overview:
- Sits between the I-cache and the decode stage.
- Requests 16-instruction I-cache lines, buffers one line, and hands instructions to decode one per cycle in program order over a valid/ready handshake.
- Handles redirects (flushes), discards stale cache responses, and turns cache faults or a misaligned redirect PC into a single exception-tagged instruction.

Parameters:
- XLEN, 64, PC/address width.
- ILEN, 32, instruction width.
- LINE_INSTR, 16, instructions per cache line; must be a power of 2.
- BOOT_PC, 'h0, PC loaded at reset.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- flush_i  in  1  redirect request; highest priority.
- redirect_pc_i  in  XLEN  new PC when flush_i=1.
- cache_req_valid_o  out  1  line request valid.
- cache_req_ready_i  in  1  cache accepts request.
- cache_req_addr_o  out  XLEN  line-aligned request address.
- cache_resp_valid_i  in  1  line response valid.
- cache_resp_ready_o  out  1  sequencer accepts response.
- cache_resp_line_i  in  LINE_INSTR*ILEN  line data; instruction k in bits [k*ILEN +: ILEN].
- cache_resp_except_i  in  1  fetch fault on this line.
- cache_resp_except_code_i  in  5  fault code.
- instr_valid_o  out  1  instruction valid to decode.
- instr_ready_i  in  1  decode accepts.
- instr_pc_o  out  XLEN  PC of the issued instruction.
- instr_o  out  ILEN  instruction word.
- instr_except_o  out  1  instruction carries an exception.
- instr_except_code_o  out  5  exception code.

Interface:
- One clock, clk_i.
- Reset rst_ni is asynchronous and active-low.

Behaviour:
- LB = LINE_INSTR*4 bytes (64 by default); OW = log2(LINE_INSTR).
- Registers:
  - pc (XLEN).
  - line buffer (LINE_INSTR*ILEN).
  - except flag and code.
  - state.
- Line address is pc with its low log2(LB) bits cleared. Offset is pc[log2(LB)-1:2].
- Reset: state=S_REQ, pc=BOOT_PC, buffer=0. All *_valid_o and cache_resp_ready_o are 0 while rst_ni=0. All data outputs are 0.

States:
- S_REQ:
  - cache_req_valid_o=1, cache_req_addr_o=line address.
  - On cache_req_ready_i: go to S_WAIT.
  - If pc[1:0]!=0 on entry: no request is made; set except=1 with code 'h00 (misaligned), go to S_ISSUE.
- S_WAIT:
  - cache_resp_ready_o=1.
  - On cache_resp_valid_i: capture line, except flag and code; go to S_ISSUE.
- S_ISSUE:
  - instr_valid_o=1, instr_pc_o=pc, instr_o=buffer[offset].
  - If except=1: instr_o='h13 (NOP) and the exception fields are driven.
  - On handshake with except=1: go to S_HALT.
  - On handshake otherwise: pc+=4. If offset was LINE_INSTR-1, go to S_REQ (next line, wrap-around); else stay in S_ISSUE.
- S_DRAIN:
  - cache_resp_ready_o=1.
  - The next response is accepted and dropped; then go to S_REQ.
- S_HALT:
  - All valids 0; wait for flush_i.

Flush (flush_i=1, any state):
- pc<=redirect_pc_i; instr_valid_o forced to 0 that cycle; except cleared.
- Next state:
  - S_DRAIN if a request is outstanding: state S_WAIT without a response this cycle, or S_REQ with a request handshake this cycle.
  - Otherwise S_REQ. This includes S_WAIT with a response this cycle: the response is accepted and dropped.
- Back-to-back flushes: the last one wins. At most one request is ever outstanding.

Latency:
- Response to instr_valid_o is 1 cycle (registered).
- Sustained throughput within a line is 1 instruction/cycle.

Optional Feature:
- Macro: LEN5_FETCH_BYPASS_EN.
- Defined: in S_WAIT, when cache_resp_valid_i=1 and flush_i=0, instr_valid_o=1 in the same cycle, with instr_o taken from cache_resp_line_i[offset] and the exception fields from the response.
  - The line is still captured.
  - If instr_ready_i=1 in that cycle: pc+=4 and the next state is S_ISSUE. If the offset was LINE_INSTR-1, the next state is S_REQ. An exception-tagged instruction accepted in this cycle goes to S_HALT.
  - Response-to-issue latency is 0 cycles.
- Undefined: behaviour is as above with 1-cycle latency.

Test Plan:
- Reset with BOOT_PC='h1000, cache ready, line words = 'h100+k, instr_ready=1: request addr 'h1000; 16 instructions with PC 'h1000..'h103C in consecutive cycles; then request addr 'h1040.
- Flush to 'h2038 while in S_ISSUE: no instr_valid that cycle; request addr 'h2000; issue starts at offset 14 ('h2038, 'h203C), then request 'h2040.
- Flush to 'h3000 while in S_WAIT, then response with line A, then line B: A is dropped (cache_resp_ready_o=1, no instr_valid); request 'h3000 is issued; B words are issued with PC 'h3000 onward.
- Response with except=1, code 'h01, at PC 'h4004: one instruction issued with PC 'h4004, instr 'h13, except=1, code 'h01. Then nothing until flush; flush to 'h5000 resumes fetching.
- Flush to 'h6002: no cache request; one instruction issued with except=1, code 'h00, PC 'h6002; then halt.
- instr_ready held 0 for 5 cycles mid-line at PC 'h1010: instr_valid, PC and instr are held stable; no PC advance.
